npu_mac_sequencer: RTL

//  Sequences one npu_mac instance through a fully-connected/conv layer: reads

---
 rtl/npu_mac_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/npu_mac_sequencer.sv
// npu_mac_sequencer: walks one npu_mac through a layer of M outputs, each the
// dot product of an N-entry weight row with the N-entry activation vector.
// For every output it streams N memory reads, waits for the MAC result,
// optionally applies ReLU and writes the result to output memory.
//
// Handshake note: there is no back-pressure anywhere in this block. Every
// strobe (mem_rd_en, mac_en, out_wr_en, done) is a single-cycle qualifier
// that is valid in the cycle it is high. mac_valid is accepted only in
// DRAIN; a pulse arriving in any other state is ignored.
//
// Debug: dbg_state carries the FSM state (IDLE=0, ISSUE=1, DRAIN=2,
// WRITE=3, DONE=4).
module npu_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cfg_layer,
    input  logic [ADDR_WIDTH-1:0] cfg_vec_len,
    input  logic [ADDR_WIDTH-1:0] cfg_num_out,
    input  logic [ADDR_WIDTH-1:0] cfg_wgt_base,
    input  logic [ADDR_WIDTH-1:0] cfg_act_base,
    input  logic [ADDR_WIDTH-1:0] cfg_out_base,
    input  logic                  cfg_relu,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
    output logic [ADDR_WIDTH-1:0] act_rd_addr,
    output logic                  mac_en,
    output logic                  start_p,
    output logic                  last_p,
    output logic [2:0]            npu_layer_in_progress,
    input  logic                  mac_valid,
    input  logic [DATA_WIDTH-1:0] mac_out,
    input  logic                  mac_overflow,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_flag,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;            // product index within output
    logic [ADDR_WIDTH-1:0] o_q, o_d;            // output index
    logic [ADDR_WIDTH-1:0] n_q, n_d;            // latched vector length
    logic [ADDR_WIDTH-1:0] m_q, m_d;            // latched output count
    logic [ADDR_WIDTH-1:0] row_q, row_d;        // wgt_base + o*N, kept incrementally
    logic [ADDR_WIDTH-1:0] act_base_q, act_base_d;
    logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
    logic                  relu_q, relu_d;
    logic [2:0]            layer_q, layer_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;            // MAC result captured in DRAIN
    logic                  ovf_q, ovf_d;
    logic                  mac_en_q, mac_en_d;
    logic                  start_p_q, start_p_d;
    logic                  last_p_q, last_p_d;

    logic                  issue;
    logic                  write;
    logic                  start_acc;
    logic                  k_last;

    assign issue     = (state_q == S_ISSUE);
    assign write     = (state_q == S_WRITE);
    assign start_acc = (state_q == S_IDLE) && start;
    assign k_last    = (k_q == n_q - 1'b1);

    // State and datapath registers; reset aborts any layer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            o_q        <= '0;
            n_q        <= '0;
            m_q        <= '0;
            row_q      <= '0;
            act_base_q <= '0;
            out_base_q <= '0;
            relu_q     <= 1'b0;
            layer_q    <= 3'd0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            mac_en_q   <= 1'b0;
            start_p_q  <= 1'b0;
            last_p_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            o_q        <= o_d;
            n_q        <= n_d;
            m_q        <= m_d;
            row_q      <= row_d;
            act_base_q <= act_base_d;
            out_base_q <= out_base_d;
            relu_q     <= relu_d;
            layer_q    <= layer_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            mac_en_q   <= mac_en_d;
            start_p_q  <= start_p_d;
            last_p_q   <= last_p_d;
        end
    end

    // Next-state, counters, config latching and the sticky overflow flag.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        o_d        = o_q;
        n_d        = n_q;
        m_d        = m_q;
        row_d      = row_q;
        act_base_d = act_base_q;
        out_base_d = out_base_q;
        relu_d     = relu_q;
        layer_d    = layer_q;
        r_d        = r_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d        = cfg_vec_len;
                    m_d        = cfg_num_out;
                    row_d      = cfg_wgt_base;
                    act_base_d = cfg_act_base;
                    out_base_d = cfg_out_base;
                    relu_d     = cfg_relu;
                    layer_d    = cfg_layer;
                    k_d        = '0;
                    o_d        = '0;
                    // An empty layer still reports completion.
                    if ((cfg_vec_len == '0) || (cfg_num_out == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (k_last) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (mac_valid) begin
                    r_d     = mac_out;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                o_d   = o_q + 1'b1;
                row_d = row_q + n_q;
                if (o_q + 1'b1 == m_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                layer_d = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Overflow only counts while the MAC is working on this layer.
        if (start_acc) begin
            ovf_d = 1'b0;
        end else if (mac_overflow && (mac_en_q || (state_q == S_DRAIN))) begin
            ovf_d = 1'b1;
        end
    end

    // MAC control strobes trail the reads by one cycle to match memory latency.
    always_comb begin
        mac_en_d  = issue;
        start_p_d = issue && (k_q == '0);
        last_p_d  = issue && k_last;
    end

    // Output decode; addresses and data are forced to zero when not strobed.
    always_comb begin
        mem_rd_en   = issue;
        wgt_rd_addr = issue ? (row_q + k_q) : '0;
        act_rd_addr = issue ? (act_base_q + k_q) : '0;
        out_wr_en   = write;
        out_wr_addr = write ? (out_base_q + o_q) : '0;
        out_wr_data = '0;
        if (write && !(relu_q && r_q[DATA_WIDTH-1])) begin
            out_wr_data = r_q;
        end
        mac_en                = mac_en_q;
        start_p               = start_p_q;
        last_p                = last_p_q;
        npu_layer_in_progress = layer_q;
        busy                  = (state_q != S_IDLE);
        done                  = (state_q == S_DONE);
        ovf_flag              = ovf_q;
        dbg_state             = state_q;
    end

endmodule
